// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and constants for the byte-serial arithmetic unit
package arith_pkg;
  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] OVF_Q = 8'hFF;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_Q = 3'd2,
    LOAD_M = 3'd3,
    CHECK  = 3'd4,
    DIV    = 3'd5,
    CORR   = 3'd6,
    OUT_R  = 3'd7
  } div_state_t;
endpackage

// File: rtl/nrdiv_step.sv
// nrdiv_step: one combinational non-restoring division iteration on {P,Q}
module nrdiv_step #(
  parameter int N = 8
) (
  input  logic [N:0]   i_p,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_m,
  output logic [N:0]   o_p,
  output logic [N-1:0] o_q
);
  logic [N:0] w_ps;
  assign w_ps = {i_p[N-1:0], i_q[N-1]};
  assign o_p  = i_p[N] ? w_ps + {1'b0, i_m} : w_ps - {1'b0, i_m};
  assign o_q  = {i_q[N-2:0], ~o_p[N]};
endmodule

// File: rtl/nrdiv8.sv
// nrdiv8: unsigned 2N/N non-restoring divider on the shared byte-serial operand bus
module nrdiv8
  import arith_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beginsig,
  input  logic         locksig,
  input  logic [N-1:0] inbus,
  output logic [N-1:0] outbus,
  output logic         endsig,
  output logic         ovf
);
  div_state_t r_state, w_next;
  logic [N:0] r_p, w_p;
  logic [N-1:0] r_q, r_m, r_out, w_q;
  logic [CNT_W-1:0] r_cnt;
  logic r_endsig, r_ovf, w_ovf;
  nrdiv_step #(.N(N)) u_step (
    .i_p(r_p),
    .i_q(r_q),
    .i_m(r_m),
    .o_p(w_p),
    .o_q(w_q)
  );
  // A >= M also catches M == 0, since A is unsigned
  assign w_ovf = r_p[N-1:0] >= r_m;
  always_comb begin
    w_next = r_state;
    if (beginsig) w_next = LOAD_A;
    else
      case (r_state)
        LOAD_A:  w_next = locksig ? LOAD_Q : LOAD_A;
        LOAD_Q:  w_next = locksig ? LOAD_M : LOAD_Q;
        LOAD_M:  w_next = locksig ? CHECK : LOAD_M;
        CHECK:   w_next = w_ovf ? OUT_R : DIV;
        DIV:     w_next = (r_cnt == CNT_W'(N - 1)) ? CORR : DIV;
        CORR:    w_next = OUT_R;
        OUT_R:   w_next = IDLE;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_p      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_out    <= '0;
      r_cnt    <= '0;
      r_endsig <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_endsig <= 1'b0;
      if (beginsig) begin
        r_ovf <= 1'b0;
        r_cnt <= '0;
      end else
        case (r_state)
          LOAD_A: if (locksig) r_p <= {1'b0, inbus};
          LOAD_Q: if (locksig) r_q <= inbus;
          LOAD_M: if (locksig) r_m <= inbus;
          CHECK:
            if (w_ovf) begin
              r_out <= OVF_Q;
              r_ovf <= 1'b1;
            end else r_cnt <= '0;
          DIV: begin
            r_p   <= w_p;
            r_q   <= w_q;
            r_cnt <= r_cnt + 1'b1;
          end
          CORR: begin
            if (r_p[N]) r_p <= r_p + {1'b0, r_m};
            r_out <= r_q;
          end
          OUT_R: begin
            r_out    <= r_ovf ? OVF_Q : r_p[N-1:0];
            r_endsig <= 1'b1;
          end
          default: ;
        endcase
    end
  end
  assign outbus = r_out;
  assign endsig = r_endsig;
  assign ovf    = r_ovf;
endmodule

// File: tb/tb_nrdiv8.sv
// tb_nrdiv8: directed and random vectors for the byte-serial divider
module tb_nrdiv8;
  logic clk = 1'b0, rst = 1'b1, beginsig = 1'b0, locksig = 1'b0;
  logic [7:0] inbus = 8'h00, outbus;
  logic endsig, ovf;
  int n_vec = 0, n_bad = 0;
  nrdiv8 dut (
    .clk(clk),
    .rst(rst),
    .beginsig(beginsig),
    .locksig(locksig),
    .inbus(inbus),
    .outbus(outbus),
    .endsig(endsig),
    .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    locksig = 1'b1;
    inbus   = b;
    tick();
    locksig = 1'b0;
    inbus   = 8'hA5;
  endtask
  task automatic load(input logic [15:0] d, input logic [7:0] m, input int gap);
    beginsig = 1'b1;
    tick();
    beginsig = 1'b0;
    send(d[15:8], gap);
    send(d[7:0], gap);
    send(m, gap);
  endtask
  task automatic run(input string tag, input logic [15:0] d, input logic [7:0] m,
                     input logic [7:0] eq, input logic [7:0] er, input logic eo, input int gap);
    load(d, m, gap);
    if (eo) begin
      tick();
      chk({tag, " ovf_q"}, outbus, 16'hFF);
      chk({tag, " ovf_q_end"}, endsig, 0);
      chk({tag, " ovf_flag"}, ovf, 1);
      tick();
      chk({tag, " ovf_r"}, outbus, 16'hFF);
      chk({tag, " ovf_r_end"}, endsig, 1);
      tick();
      chk({tag, " ovf_end_low"}, endsig, 0);
      chk({tag, " ovf_held"}, ovf, 1);
    end else begin
      repeat (10) tick();
      chk({tag, " quot"}, outbus, eq);
      chk({tag, " quot_end"}, endsig, 0);
      tick();
      chk({tag, " rem"}, outbus, er);
      chk({tag, " rem_end"}, endsig, 1);
      chk({tag, " ovf"}, ovf, 0);
      tick();
      chk({tag, " end_low"}, endsig, 0);
      chk({tag, " rem_held"}, outbus, er);
    end
  endtask
  initial begin
    logic [15:0] d;
    logic [7:0] m, a;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_out", outbus, 0);
    chk("reset_end", endsig, 0);
    chk("reset_ovf", ovf, 0);
    run("basic", 16'h1234, 8'h45, 8'h43, 8'h25, 1'b0, 0);
    run("max", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 0);
    run("ovf_eq", 16'h4500, 8'h45, 8'h00, 8'h00, 1'b1, 0);
    run("div0", 16'h0010, 8'h00, 8'h00, 8'h00, 1'b1, 0);
    run("zero_num", 16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 0);
    run("gaps", 16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 3);
    load(16'h1234, 8'h45, 0);
    repeat (5) begin
      tick();
      chk("abort_no_end", endsig, 0);
      chk("abort_hold", outbus, 8'h0F);
    end
    run("abort_reload", 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 0);
    run("ovf_pre_rst", 16'hFF00, 8'h01, 8'h00, 8'h00, 1'b1, 0);
    load(16'h1234, 8'h45, 0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out", outbus, 0);
    chk("rst_end", endsig, 0);
    chk("rst_ovf", ovf, 0);
    repeat (12) begin
      tick();
      chk("rst_idle_out", outbus, 0);
      chk("rst_idle_end", endsig, 0);
    end
    for (int i = 0; i < 1000; i++) begin
      m = 8'($urandom_range(0, 255));
      d = 16'($urandom_range(0, 65535));
      if (i[0] && m != 0) begin
        a = 8'($urandom % m);
        d[15:8] = a;
      end
      if (d[15:8] >= m) run("rand", d, m, 8'h00, 8'h00, 1'b1, 0);
      else run("rand", d, m, 8'(d / 16'(m)), 8'(d % 16'(m)), 1'b0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/nrdiv8.md
Name: nrdiv8

Overview:
- Unsigned 16/8 non-restoring divider: the inverse operation of the Booth radix-4 multiplier (boothr4), on the same byte-serial bus protocol.
- Operands are loaded byte-by-byte on `inbus`, qualified by `beginsig`/`locksig`.
- 8 iterations run; quotient then remainder are returned on `outbus`, with `endsig` on the last byte.
- Sits beside boothr4 on the shared 8-bit operand/result bus of the arithmetic unit.

Parameters:
- N, 8, operand/quotient/remainder width in bits. Dividend is 2N. Bus width is N. Only N=8 is verified.

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- beginsig  in  1  one-cycle start pulse; aborts any operation in progress
- locksig  in  1  qualifies `inbus` as a valid operand byte during load
- inbus  in  8  operand byte
- outbus  out  8  result byte (registered)
- endsig  out  1  one-cycle pulse, coincident with the remainder byte
- ovf  out  1  divide overflow / divide-by-zero flag; held until next beginsig

Behaviour:
- Reset:
  - rst sampled on clk rising edge; priority over everything.
  - State=IDLE; outbus=8'h00, endsig=0, ovf=0; all internal registers cleared.
- States: IDLE, LOAD_A, LOAD_Q, LOAD_M, CHECK, DIV, CORR, OUT_R.
- IDLE:
  - beginsig=1 -> LOAD_A; ovf cleared, endsig=0.
  - Other inputs ignored.
- beginsig=1 in any non-reset state -> LOAD_A. Restart/abort: ovf cleared, endsig=0, outbus holds its value, counter cleared.
- LOAD_A / LOAD_Q / LOAD_M:
  - On an edge with locksig=1, capture inbus in this order: dividend high byte (A), dividend low byte (Q), divisor (M). Advance one state per captured byte.
  - locksig=0: hold state, no capture (unbounded wait).
  - A byte is captured on every locksig=1 edge; no de-duplication.
- CHECK (1 cycle):
  - If M==0 or A>=M (overflow, includes divide-by-zero):
    - outbus<=8'hFF, ovf<=1 -> OUT_R.
    - OUT_R then drives outbus<=8'hFF (remainder), endsig<=1.
  - Else -> DIV, counter<=0, partial remainder P (N+1 bits, signed) <= {0,A}.
- DIV (exactly N cycles), one iteration per edge:
  - Shift {P,Q} left 1.
  - If P>=0 (pre-shift sign): P<=P_shifted - M; else P<=P_shifted + M.
  - Q[0] <= ~new sign of P.
  - counter increments; after the Nth iteration -> CORR.
- CORR (1 cycle):
  - If P<0, P<=P+M.
  - outbus<=Q (quotient), then -> OUT_R.
- OUT_R (1 cycle): outbus<=P[N-1:0] (remainder), endsig<=1 -> IDLE.
- endsig is high for exactly one cycle. Next edge deasserts it, unless beginsig restarts (also 0).
- Latency, with M captured on edge n:
  - Normal: quotient visible after edge n+10; remainder + endsig after edge n+11.
  - Overflow: 8'hFF after n+1; 8'hFF + endsig after n+2.
- outbus holds the remainder (or FF) until the next result is driven or rst.
- locksig is ignored outside the LOAD states; inbus is don't-care there.
- Arithmetic:
  - P is N+1 bits two's complement.
  - Quotient is exact unsigned floor(D/M) for A<M; remainder is in [0, M-1].

Decomposition:
- Shared package `arith_pkg`:
  - state encoding typedef (3-bit enum, values above)
  - constants DIV_W=8, CNT_W=$clog2(DIV_W+1), OVF_Q=8'hFF
- One sub-module `nrdiv_step`: combinational single iteration.
  - Inputs: P, Q, M.
  - Outputs: next P, next Q.
- Top holds the FSM, counter and bus registers.

Test Plan:
- Basic:
  - Stimulus: rst; beginsig; locksig bytes 8'h12, 8'h34, 8'h45.
  - Response: outbus=8'h43 after edge n+10; 8'h25 with endsig=1 after n+11; ovf=0; endsig low next cycle.
- Max valid:
  - Stimulus: dividend 16'hFEFF / 8'hFF.
  - Response: quotient 8'hFF, remainder 8'hFE, ovf=0.
- Overflow:
  - Stimulus: dividend 16'h4500 / 8'h45; then dividend 16'h0010 / 8'h00.
  - Response: each gives outbus=FF,FF; endsig after n+2; ovf=1 until next beginsig.
- locksig gaps:
  - Stimulus: 16'h00FF / 8'h10 with locksig low for 3 cycles between each byte.
  - Response: correct capture; 8'h0F then 8'h0F.
- Abort/reset mid-operation:
  - Stimulus: beginsig at DIV iteration 4, then reload 16'h0064 / 8'h07.
  - Response: 8'h0E then 8'h02, no spurious endsig.
  - Stimulus: rst asserted during DIV.
  - Response: outbus=0, endsig=0, ovf=0 next edge; IDLE.
- Random:
  - Stimulus: 1000 random dividend/divisor pairs.
  - Response: checked against D/M and D%M, or the overflow rule.
